seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//   Downstream consumer of the 2-bit scan counter. Turns the counter's digit index plus a
//   16-bit display word from the CPU into registered active-low anode/segment drives for a
//   4-digit 7-seg display. Adds ghost-suppression blanking on every digit change.
//   Adds a frame-synchronous load handshake so a new word never tears mid-frame.
// PARAMETERS
//   BLANK_CYCLES  2        clock periods all anodes are held off after each digit change (0 = none)
//   RESET_DATA    16'h0000 displayed word after reset
// PORTS
//   CLK        in   1   single clock for the block
//   Reset      in   1   asynchronous, active-low reset
//   digit_sel  in   2   digit index from the scan counter (0 = rightmost, nibble [3:0])
//   data_in    in   16  word to display, nibble n shown on digit n
//   load       in   1   request to latch data_in; accepted only when ready=1
//   ready      out  1   1 = no update pending, load will be accepted
//   AN         out  4   anode enables, active-low, AN[n] drives digit n
//   SEG        out  8   {dp,g,f,e,d,c,b,a}, active-low; dp always 1 (off)
// BEHAVIOUR
//   Reset (Reset=0, async): state=BLANK, cnt=0, sel_q=0, disp=RESET_DATA, pending=0,
//     pend_data=0, AN=4'hF, SEG=8'hFF, ready=1. After release, first edge enters DRIVE.
//   sel_q registers digit_sel every edge; change = (digit_sel != sel_q) at that edge.
//   FSM {BLANK, DRIVE}, all outputs registered:
//     - change edge, BLANK_CYCLES>0: state<=BLANK, cnt<=BLANK_CYCLES-1, AN<=4'hF, SEG<=8'hFF.
//     - BLANK, cnt>0: cnt<=cnt-1, outputs stay off.
//     - BLANK, cnt==0, no change: state<=DRIVE, AN<=~(4'b1<<sel_q), SEG<=dec(disp nibble sel_q).
//     - change while in BLANK restarts the count (new digit gets full blanking).
//     - BLANK_CYCLES=0: change edge goes straight to DRIVE with the new digit (1-cycle latency).
//     => AN is all-off for exactly BLANK_CYCLES periods starting at the change edge.
//   DRIVE refreshes SEG from disp every edge (disp changes appear next edge).
//   Decode dec(): hex 0..F, gfedcba active-low: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8
//     8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E (SEG byte incl. dp=1).
//   Handshake: load && ready at an edge: pend_data<=data_in, pending<=1, ready<=0.
//     load while ready=0: ignored, data dropped, no error.
//   Frame boundary = change edge with sel_q==3 && digit_sel==0 (wrap). If pending:
//     disp<=pend_data, pending<=0, ready<=1. Load accepted on the boundary edge itself
//     (ready=1 there) is held to the NEXT boundary, never applied the same edge.
//   Non-wrap jumps (e.g. 1->3) are normal changes, not frame boundaries.
//   Reset mid-blank or mid-pending: pending update discarded, disp returns to RESET_DATA.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: digits 3..1 output SEG=8'hFF (AN still asserted in DRIVE)
//     when that nibble and all higher nibbles of disp are 0; digit 0 always shown.
//   Not defined: all four digits always show their hex value, including leading zeros.
// TESTING
//   1. Reset low mid-run -> AN=F, SEG=FF, ready=1 immediately (async); disp=RESET_DATA.
//   2. BLANK_CYCLES=2, disp=16'h12A8, digit_sel 0->1 -> AN=F for 2 cycles, then AN=D, SEG=A4? no:
//      nibble1=A -> AN=4'hD, SEG=8'h88; stepping to 3 -> AN=7, SEG=F9.
//   3. load=1 data_in=16'hBEEF mid-frame -> ready=0 next edge; display unchanged until
//      3->0 wrap, then disp=BEEF, ready=1; digit0 shows SEG=8E.
//   4. Second load 16'h0001 while ready=0 -> ignored; after wrap disp=BEEF, not 0001.
//   5. digit_sel toggles 0->1->0 one cycle apart with BLANK_CYCLES=2 -> AN stays F until
//      2 cycles after the last change, then AN=E.
//   6. disp=16'h0070: macro on -> digits 3,2 SEG=FF, digit1 F8, digit0 C0;
//      macro off -> digits 3,2 SEG=C0.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Registered 4-digit 7-seg scan driver with per-digit ghost blanking and a frame-synchronous load.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module seg_scan_driver #(
  parameter int unsigned BLANK_CYCLES = 2,
  parameter logic [15:0] RESET_DATA   = 16'h0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [1:0]  digit_sel,
  input  logic [15:0] data_in,
  input  logic        load,
  output logic        ready,
  output logic [3:0]  AN,
  output logic [7:0]  SEG
);

  localparam int unsigned CW    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int unsigned BC_M1 = (BLANK_CYCLES != 0) ? BLANK_CYCLES - 1 : 0;

  typedef enum logic {BLANK, DRIVE} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      sel_q;
  logic [15:0]     disp_q;
  logic [15:0]     pend_data_q;
  logic            pending_q;
  logic            ready_q;
  logic [3:0]      an_q;
  logic [7:0]      seg_q;

  logic            change_d;
  logic            wrap_d;

  function automatic logic [7:0] dec(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] seg_for(input logic [1:0] idx, input logic [15:0] word);
`ifdef LEADING_ZERO_BLANK_EN
    logic [15:0] hi;
    hi = word >> {idx, 2'b00};
    if (idx != 2'd0 && hi == 16'h0000) return 8'hFF;
`endif
    return dec(word[{idx, 2'b00} +: 4]);
  endfunction

  function automatic logic [3:0] an_for(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  assign change_d = (digit_sel != sel_q);
  assign wrap_d   = change_d && (sel_q == 2'd3) && (digit_sel == 2'd0);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= BLANK;
      cnt_q       <= '0;
      sel_q       <= '0;
      disp_q      <= RESET_DATA;
      pend_data_q <= '0;
      pending_q   <= 1'b0;
      ready_q     <= 1'b1;
      an_q        <= '1;
      seg_q       <= '1;
    end else begin
      sel_q <= digit_sel;

      // A change always restarts blanking, even if already blanking.
      if (change_d && BLANK_CYCLES != 0) begin
        state_q <= BLANK;
        cnt_q   <= CW'(BC_M1);
        an_q    <= '1;
        seg_q   <= '1;
      end else if (change_d) begin
        state_q <= DRIVE;
        an_q    <= an_for(digit_sel);
        seg_q   <= seg_for(digit_sel, disp_q);
      end else if (state_q == BLANK && cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end else begin
        state_q <= DRIVE;
        an_q    <= an_for(sel_q);
        seg_q   <= seg_for(sel_q, disp_q);
      end

      // ready mirrors !pending, so acceptance and frame commit never coincide.
      if (load && ready_q) begin
        pend_data_q <= data_in;
        pending_q   <= 1'b1;
        ready_q     <= 1'b0;
      end else if (wrap_d && pending_q) begin
        disp_q    <= pend_data_q;
        pending_q <= 1'b0;
        ready_q   <= 1'b1;
      end
    end
  end

  assign ready = ready_q;
  assign AN    = an_q;
  assign SEG   = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: elapsed-edge display model checked every cycle, plus directed literal checks.
module tb_seg_scan_driver;

  localparam int unsigned B  = 2;
  localparam logic [15:0] RD = 16'h0000;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic [1:0]  digit_sel = 2'd0;
  logic [15:0] data_in = 16'h0000;
  logic        load = 1'b0;
  logic        ready;
  logic [3:0]  AN;
  logic [7:0]  SEG;

  int checks = 0;
  int errors = 0;

  seg_scan_driver #(.BLANK_CYCLES(B), .RESET_DATA(RD)) dut (
    .CLK(CLK), .Reset(Reset), .digit_sel(digit_sel), .data_in(data_in),
    .load(load), .ready(ready), .AN(AN), .SEG(SEG)
  );

  always #5 CLK = ~CLK;

  logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [7:0] seg_of(input logic [1:0] d, input logic [15:0] w);
    logic [3:0] nib;
`ifdef LEADING_ZERO_BLANK_EN
    if (d != 2'd0 && (w >> (4 * d)) == 16'h0000) return 8'hFF;
`endif
    nib = 4'(w >> (4 * d));
    return HEX[nib];
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: k = edges since the last digit change; dark while k < B.
  int unsigned m_k;
  logic [1:0]  m_sel;
  logic [15:0] m_disp, m_pdata;
  logic        m_pend;
  logic [3:0]  e_an;
  logic [7:0]  e_seg;
  logic        e_ready;

  initial begin
    logic chg, wrapv;
    forever begin
      @(posedge CLK or negedge Reset);
      if (!Reset) begin
        m_k = B; m_sel = 2'd0; m_disp = RD; m_pend = 1'b0; m_pdata = 16'h0;
        e_an = 4'hF; e_seg = 8'hFF; e_ready = 1'b1;
      end else begin
        chg   = (digit_sel != m_sel);
        wrapv = chg && m_sel == 2'd3 && digit_sel == 2'd0;
        if (chg) m_k = 0;
        else if (m_k < B) m_k++;
        if (m_k < B) begin
          e_an = 4'hF; e_seg = 8'hFF;
        end else begin
          e_an = ~(4'b0001 << digit_sel); e_seg = seg_of(digit_sel, m_disp);
        end
        if (load && e_ready) begin
          m_pdata = data_in; m_pend = 1'b1; e_ready = 1'b0;
        end else if (wrapv && m_pend) begin
          m_disp = m_pdata; m_pend = 1'b0; e_ready = 1'b1;
        end
        m_sel = digit_sel;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      chk("model_AN", 16'(AN), 16'(e_an));
      chk("model_SEG", 16'(SEG), 16'(e_seg));
      chk("model_ready", 16'(ready), 16'(e_ready));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic sweep_to(input logic [1:0] d);
    digit_sel = d;
    step(3);
  endtask

  initial begin
    logic [7:0] lead;
`ifdef LEADING_ZERO_BLANK_EN
    lead = 8'hFF;
`else
    lead = 8'hC0;
`endif
    step(1);
    chk("rst_AN", 16'(AN), 16'hF);
    chk("rst_SEG", 16'(SEG), 16'hFF);
    chk("rst_ready", 16'(ready), 16'h1);
    Reset = 1'b1;
    step(1);
    chk("first_AN", 16'(AN), 16'hE);
    chk("first_SEG", 16'(SEG), 16'hC0);

    load = 1'b1; data_in = 16'h12A8;
    step(1);
    load = 1'b0;
    chk("load_ready0", 16'(ready), 16'h0);
    sweep_to(2'd1); sweep_to(2'd2); sweep_to(2'd3);
    digit_sel = 2'd0;
    step(1);
    chk("wrap_ready1", 16'(ready), 16'h1);
    step(2);
    chk("d0_AN", 16'(AN), 16'hE);
    chk("d0_SEG", 16'(SEG), 16'h80);

    digit_sel = 2'd1;
    step(1); chk("blank1_AN", 16'(AN), 16'hF);
    step(1); chk("blank2_AN", 16'(AN), 16'hF);
    step(1);
    chk("d1_AN", 16'(AN), 16'hD);
    chk("d1_SEG", 16'(SEG), 16'h88);
    sweep_to(2'd3);
    chk("d3_AN", 16'(AN), 16'h7);
    chk("d3_SEG", 16'(SEG), 16'hF9);

    load = 1'b1; data_in = 16'hBEEF;
    step(1);
    chk("beef_ready0", 16'(ready), 16'h0);
    data_in = 16'h0001;
    step(1);
    load = 1'b0;
    chk("nontear_SEG", 16'(SEG), 16'hF9);
    digit_sel = 2'd0;
    step(1);
    chk("beef_ready1", 16'(ready), 16'h1);
    step(2);
    chk("beef_AN", 16'(AN), 16'hE);
    chk("beef_SEG", 16'(SEG), 16'h8E);

    sweep_to(2'd1); sweep_to(2'd2); sweep_to(2'd3);
    digit_sel = 2'd0; load = 1'b1; data_in = 16'h0070;
    step(1);
    load = 1'b0;
    chk("bnd_load_ready0", 16'(ready), 16'h0);
    step(2);
    chk("bnd_held_SEG", 16'(SEG), 16'h8E);

    digit_sel = 2'd1;
    step(1);
    digit_sel = 2'd0;
    step(1); chk("glitch_k0_AN", 16'(AN), 16'hF);
    step(1); chk("glitch_k1_AN", 16'(AN), 16'hF);
    step(1); chk("glitch_AN", 16'(AN), 16'hE);

    sweep_to(2'd1); sweep_to(2'd2); sweep_to(2'd3); sweep_to(2'd0);
    chk("z_d0_SEG", 16'(SEG), 16'hC0);
    sweep_to(2'd1);
    chk("z_d1_SEG", 16'(SEG), 16'hF8);
    sweep_to(2'd2);
    chk("z_d2_SEG", 16'(SEG), 16'(lead));
    sweep_to(2'd3);
    chk("z_d3_SEG", 16'(SEG), 16'(lead));
    chk("z_d3_AN", 16'(AN), 16'h7);

    load = 1'b1; data_in = 16'h1234;
    step(1);
    load = 1'b0;
    Reset = 1'b0;
    #1;
    chk("async_AN", 16'(AN), 16'hF);
    chk("async_SEG", 16'(SEG), 16'hFF);
    chk("async_ready", 16'(ready), 16'h1);
    digit_sel = 2'd0;
    step(1);
    Reset = 1'b1;
    step(1);
    chk("rerst_SEG", 16'(SEG), 16'hC0);
    sweep_to(2'd1);
    chk("rerst_d1_SEG", 16'(SEG), 16'(lead));
    sweep_to(2'd2); sweep_to(2'd3); sweep_to(2'd0);
    chk("discard_SEG", 16'(SEG), 16'hC0);
    chk("discard_ready", 16'(ready), 16'h1);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
